// File: rtl/fp_adder_seq.sv
// fp_adder_seq: multi-cycle adder for a 13-bit floating-point format.
// Each value is a sign bit, a 4-bit exponent and an 8-bit fraction, and it
// means 0.frac * 2^exp. A nonzero value is normalized (frac[7]=1). Zero is
// frac=0; a zero result is always produced as sign=0 and exp=0.
// Alignment and normalization each shift one bit per clock, so the block
// needs no barrel shifter.
//
// Ports:
//   clk                   system clock, rising edge
//   reset_n               asynchronous active-low reset
//   start                 request; sampled only while ready=1
//   sign1/exp1/frac1      operand A
//   sign2/exp2/frac2      operand B
//   ready                 high in IDLE; a start is accepted
//   done                  one-cycle pulse while the result is valid
//   sign_out/exp_out/frac_out  result; held until the next done
//   overflow              result saturated; valid with done, held until the next done
module fp_adder_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       sign1,
  input  logic [3:0] exp1,
  input  logic [7:0] frac1,
  input  logic       sign2,
  input  logic [3:0] exp2,
  input  logic [7:0] frac2,
  output logic       ready,
  output logic       done,
  output logic       sign_out,
  output logic [3:0] exp_out,
  output logic [7:0] frac_out,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;

  state_e     state_q, state_d;
  logic       sb_q, sb_d, ss_q, ss_d;           // big / small operand signs
  logic [3:0] eb_q, eb_d, es_q, es_d;           // eb_q is also the result exponent
  logic [7:0] fb_q, fb_d, fs_q, fs_d;
  logic [8:0] sum_q, sum_d;                     // bit 8 holds the carry of the add
  logic       sign_out_q, sign_out_d;
  logic [3:0] exp_out_q, exp_out_d;
  logic [7:0] frac_out_q, frac_out_d;
  logic       overflow_q, overflow_d;

  logic [11:0] key_a, key_b;
  logic        a_wins;

  // A zero operand gets key 0, so it always orders as the small one.
  // On equal keys operand A is taken as big.
  assign key_a  = (frac1 == 8'd0) ? 12'd0 : {exp1, frac1};
  assign key_b  = (frac2 == 8'd0) ? 12'd0 : {exp2, frac2};
  assign a_wins = (key_a >= key_b);

  always_comb begin
    // NOTE: every signal written here gets its default first; a missing
    // assignment on one branch would otherwise infer a latch.
    state_d    = state_q;
    sb_d       = sb_q;
    eb_d       = eb_q;
    fb_d       = fb_q;
    ss_d       = ss_q;
    es_d       = es_q;
    fs_d       = fs_q;
    sum_d      = sum_q;
    sign_out_d = sign_out_q;
    exp_out_d  = exp_out_q;
    frac_out_d = frac_out_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (a_wins) begin
            {sb_d, eb_d, fb_d} = {sign1, exp1, frac1};
            {ss_d, es_d, fs_d} = {sign2, exp2, frac2};
          end else begin
            {sb_d, eb_d, fb_d} = {sign2, exp2, frac2};
            {ss_d, es_d, fs_d} = {sign1, exp1, frac1};
          end
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        // Bits shifted out of the small fraction are dropped (truncation).
        if ((es_q < eb_q) && (fs_q != 8'd0)) begin
          fs_d = fs_q >> 1;
          es_d = es_q + 4'd1;
        end else begin
          state_d = ADD;
        end
      end

      ADD: begin
        // The magnitude ordering guarantees fb >= fs, so the difference
        // never goes negative and the result sign is simply sb.
        if (sb_q == ss_q) sum_d = {1'b0, fb_q} + {1'b0, fs_q};
        else              sum_d = {1'b0, fb_q} - {1'b0, fs_q};
        state_d = NORM;
      end

      NORM: begin
        // The output registers are loaded on the way into DONE, so they
        // already hold the new result during the done pulse.
        if (sum_q == 9'd0) begin
          {sign_out_d, exp_out_d, frac_out_d, overflow_d} = '0;
          state_d = DONE;
        end else if (sum_q[8]) begin
          if (eb_q != 4'd15) begin
            {sign_out_d, exp_out_d, frac_out_d} = {sb_q, eb_q + 4'd1, sum_q[8:1]};
            overflow_d = 1'b0;
          end else begin
            {sign_out_d, exp_out_d, frac_out_d} = {sb_q, 4'd15, 8'hFF};
            overflow_d = 1'b1;
          end
          state_d = DONE;
        end else if (sum_q[7]) begin
          {sign_out_d, exp_out_d, frac_out_d} = {sb_q, eb_q, sum_q[7:0]};
          overflow_d = 1'b0;
          state_d    = DONE;
        end else if (eb_q != 4'd0) begin
          sum_d = sum_q << 1;
          eb_d  = eb_q - 4'd1;
        end else begin
          // The exponent cannot go below zero: flush to +0.
          {sign_out_d, exp_out_d, frac_out_d, overflow_d} = '0;
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sb_q       <= 1'b0;
      eb_q       <= 4'd0;
      fb_q       <= 8'd0;
      ss_q       <= 1'b0;
      es_q       <= 4'd0;
      fs_q       <= 8'd0;
      sum_q      <= 9'd0;
      sign_out_q <= 1'b0;
      exp_out_q  <= 4'd0;
      frac_out_q <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      eb_q       <= eb_d;
      fb_q       <= fb_d;
      ss_q       <= ss_d;
      es_q       <= es_d;
      fs_q       <= fs_d;
      sum_q      <= sum_d;
      sign_out_q <= sign_out_d;
      exp_out_q  <= exp_out_d;
      frac_out_q <= frac_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign sign_out = sign_out_q;
  assign exp_out  = exp_out_q;
  assign frac_out = frac_out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp_adder_seq.sv
// Self-checking bench for fp_adder_seq. Directed vectors with hand-computed
// results are pushed into a scoreboard queue when they are issued; a monitor
// pops and compares whenever done is seen.
module tb_fp_adder_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       sign1, sign2;
  logic [3:0] exp1, exp2;
  logic [7:0] frac1, frac2;
  logic       ready, done, sign_out, overflow;
  logic [3:0] exp_out;
  logic [7:0] frac_out;

  fp_adder_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .sign1    (sign1),
    .exp1     (exp1),
    .frac1    (frac1),
    .sign2    (sign2),
    .exp2     (exp2),
    .frac2    (frac2),
    .ready    (ready),
    .done     (done),
    .sign_out (sign_out),
    .exp_out  (exp_out),
    .frac_out (frac_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] res;   // {sign, exp, frac}
    logic        ovf;
    int          lat;   // expected start-to-done cycles, -1 = not checked
    int          t0;
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        item_t it;
        it = sb_q.pop_front();
        check({it.name, "_result"}, {18'd0, sign_out, exp_out, frac_out, overflow},
              {18'd0, it.res, it.ovf});
        if (it.lat >= 0) check({it.name, "_latency"}, cyc - it.t0, it.lat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic issue(input string name,
                       input logic s1, input logic [3:0] e1, input logic [7:0] f1,
                       input logic s2, input logic [3:0] e2, input logic [7:0] f2,
                       input logic [12:0] res, input logic ovf, input int lat);
    item_t it;
    wait_ready();
    {sign1, exp1, frac1} = {s1, e1, f1};
    {sign2, exp2, frac2} = {s2, e2, f2};
    start = 1'b1;
    it.name = name; it.res = res; it.ovf = ovf; it.lat = lat; it.t0 = cyc;
    sb_q.push_back(it);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    {sign1, exp1, frac1} = '0;
    {sign2, exp2, frac2} = '0;
    #2;
    check("reset_outputs", {26'd0, ready, done, sign_out, exp_out, frac_out, overflow},
          {26'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    issue("add_3_5",    0, 4'd2,  8'hC0, 0, 4'd3,  8'hA0, {1'b0, 4'd4,  8'h80}, 1'b0, 5);
    issue("add_5_m3",   0, 4'd3,  8'hA0, 1, 4'd2,  8'hC0, {1'b0, 4'd2,  8'h80}, 1'b0, -1);
    issue("add_7_m7",   0, 4'd3,  8'hE0, 1, 4'd3,  8'hE0, {1'b0, 4'd0,  8'h00}, 1'b0, 4);
    issue("add_127_1",  0, 4'd7,  8'hFE, 0, 4'd1,  8'h80, {1'b0, 4'd8,  8'h80}, 1'b0, 10);
    issue("saturate",   0, 4'd15, 8'hFF, 0, 4'd15, 8'hFF, {1'b0, 4'd15, 8'hFF}, 1'b1, -1);
    issue("add_1_0",    0, 4'd1,  8'h80, 0, 4'd0,  8'h00, {1'b0, 4'd1,  8'h80}, 1'b0, -1);
    issue("add_0_m5",   0, 4'd0,  8'h00, 1, 4'd3,  8'hA0, {1'b1, 4'd3,  8'hA0}, 1'b0, -1);
    issue("add_m3_m5",  1, 4'd2,  8'hC0, 1, 4'd3,  8'hA0, {1'b1, 4'd4,  8'h80}, 1'b0, -1);
    issue("underflow",  0, 4'd1,  8'h81, 1, 4'd1,  8'h80, {1'b0, 4'd0,  8'h00}, 1'b0, -1);
    issue("max_align",  0, 4'd15, 8'h80, 0, 4'd0,  8'h80, {1'b0, 4'd15, 8'h80}, 1'b0, -1);
    issue("add_0_0",    1, 4'd0,  8'h00, 1, 4'd0,  8'h00, {1'b0, 4'd0,  8'h00}, 1'b0, -1);

    // start while busy is ignored: the monitor flags any extra done.
    issue("busy_op",    0, 4'd7,  8'hFE, 0, 4'd1,  8'h80, {1'b0, 4'd8,  8'h80}, 1'b0, 10);
    @(negedge clk);
    {sign1, exp1, frac1} = {1'b0, 4'd2, 8'hC0};
    {sign2, exp2, frac2} = {1'b0, 4'd2, 8'hC0};
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;

    // Reset during ALIGN aborts at once, without waiting for a clock edge.
    issue("aborted",    0, 4'd7,  8'hFE, 0, 4'd1,  8'h80, {1'b0, 4'd8,  8'h80}, 1'b0, -1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_outputs", {26'd0, ready, done, sign_out, exp_out, frac_out, overflow},
          {26'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0});
    void'(sb_q.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    issue("after_reset", 0, 4'd2, 8'hC0, 0, 4'd3,  8'hA0, {1'b0, 4'd4,  8'h80}, 1'b0, 5);

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
